// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
//
// Front-end fetch stage. It owns the program counter and issues one word fetch
// at a time to instruction memory. Each returned word goes into the IF/ID
// pipeline register. If decode is stalled when a word returns, the word is
// held in a one-entry skid buffer. A redirect from a later stage flushes IF/ID
// and the skid buffer, and squashes any fetch still in flight.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   PC_STEP   byte increment between sequential fetches
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   imem_req_valid/addr/ready      fetch request handshake (addr = current PC)
//   imem_resp_valid/data           returned instruction word
//   redirect_valid/pc              taken branch/jump target from a later stage
//   id_stall                       decode cannot accept a new instruction
//   if_id_valid/instr/pc/pc_plus4  IF/ID pipeline register to the decoder
//
// Optional feature (macro INSTR_FETCH_PERF_CNT_EN):
//   perf_fetch_cnt  instructions loaded into IF/ID
//   perf_stall_cnt  cycles with if_id_valid && id_stall
// -----------------------------------------------------------------------------
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4
`ifdef INSTR_FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  // The skid buffer is full exactly when the FSM is in ST_SKID, so it needs
  // no separate valid flag.
  typedef enum logic [1:0] {
    ST_REQ,   // request outstanding on the bus
    ST_WAIT,  // request accepted, waiting for the word
    ST_SKID,  // word parked in the skid buffer, waiting for IF/ID to free
    ST_DROP   // waiting for a squashed response to drain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic        if_free;
  logic        load_en;

  assign if_free = !if_id_valid_q || !id_stall;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pend_pc_d     = pend_pc_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    if_id_valid_d = if_id_valid_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_pc4_d   = if_id_pc4_q;
    load_en       = 1'b0;

    // Decoder takes the current instruction; a load below overrides this.
    if (if_id_valid_q && !id_stall) if_id_valid_d = 1'b0;

    if (redirect_valid) begin
      // Redirect beats stall. A request accepted this cycle, or one still in
      // flight, must have its response drained in ST_DROP.
      pc_d          = redirect_pc;
      if_id_valid_d = 1'b0;
      unique case (state_q)
        ST_REQ:  state_d = imem_req_ready  ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
        ST_SKID: state_d = ST_REQ;
        ST_DROP: state_d = imem_resp_valid ? ST_REQ  : ST_DROP;
        default: state_d = ST_REQ;
      endcase
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (imem_req_ready) begin
            pend_pc_d = pc_q;
            state_d   = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_resp_valid) begin
            if (if_free) begin
              load_en       = 1'b1;
              if_id_valid_d = 1'b1;
              if_id_instr_d = imem_resp_data;
              if_id_pc_d    = pend_pc_q;
              if_id_pc4_d   = pend_pc_q + STEP;
              pc_d          = pend_pc_q + STEP;
              state_d       = ST_REQ;
            end else begin
              skid_instr_d = imem_resp_data;
              skid_pc_d    = pend_pc_q;
              state_d      = ST_SKID;
            end
          end
        end
        ST_SKID: begin
          if (if_free) begin
            load_en       = 1'b1;
            if_id_valid_d = 1'b1;
            if_id_instr_d = skid_instr_q;
            if_id_pc_d    = skid_pc_q;
            if_id_pc4_d   = skid_pc_q + STEP;
            pc_d          = skid_pc_q + STEP;
            state_d       = ST_REQ;
          end
        end
        ST_DROP: begin
          if (imem_resp_valid) state_d = ST_REQ;
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_pc4_q   <= if_id_pc4_d;
    end
    // NOTE: pure datapath holding registers are left out of reset. They are
    // only read in states that are entered after they have been written.
    pend_pc_q    <= pend_pc_d;
    skid_instr_q <= skid_instr_d;
    skid_pc_q    <= skid_pc_d;
  end

  // Gating with rst keeps the bus quiet for the whole reset interval.
  assign imem_req_valid = (state_q == ST_REQ) && !rst;
  assign imem_req_addr  = pc_q;
  assign if_id_valid    = if_id_valid_q;
  assign if_id_instr    = if_id_instr_q;
  assign if_id_pc       = if_id_pc_q;
  assign if_id_pc_plus4 = if_id_pc4_q;

`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load_en)                  fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (if_id_valid_q && id_stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  // Keep load_en referenced so the default build has no dangling signal.
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_stage
//
// Randomised bench for instr_fetch_stage. A behavioural memory answers each
// accepted request after 1-3 cycles with a word derived from its address.
// The reference model treats the fetch stream as "sequential words from the
// last reset/redirect target". Expected IF/ID entries are queued from that
// stream. A negedge monitor pops and compares one entry each time a new
// instruction appears in IF/ID.
// -----------------------------------------------------------------------------
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC  = 32'hFFFF_FFF8;  // exercises PC wrap
  localparam logic [31:0] STEP    = 32'd4;
  localparam int          N_CYC   = 4000;
  localparam int          MID_RST = 1500;

  logic        clk, rst;
  logic        imem_req_valid, imem_req_ready, imem_resp_valid;
  logic [31:0] imem_req_addr, imem_resp_data;
  logic        redirect_valid, id_stall;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc_plus4;
`ifdef INSTR_FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  instr_fetch_stage #(.RESET_PC(RST_PC), .PC_STEP(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_stall       (id_stall),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus4 (if_id_pc_plus4)
`ifdef INSTR_FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  // ---------------- behavioural memory + stimulus ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];

  initial begin
    int    stall_left = 0;
    bit    directed;
    int    lat;
    mreq_t m;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_stall = 1'b0;
    for (int c = 0; c < N_CYC; c++) begin
      @(posedge clk); #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (mq.size() > 0 && mq[0].due <= c) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(mq[0].addr);
        mq.delete(0);
      end
      rst      = (c < 3) || (c == MID_RST);
      directed = (c >= 3) && (c < 13);
      // After the mid-run reset, ready stays low long enough for the
      // abandoned response to arrive while the stage sits in REQ.
      if (rst || directed || (c > MID_RST && c <= MID_RST + 4)) begin
        imem_req_ready = !rst && directed;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
      end else begin
        imem_req_ready = ($urandom_range(0, 3) != 0);
        if (stall_left > 0) begin
          id_stall = 1'b1;
          stall_left--;
        end else begin
          id_stall = ($urandom_range(0, 4) == 0);
          if ($urandom_range(0, 30) == 0) stall_left = 4;
        end
        redirect_valid = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 3))
          0:       redirect_pc = 32'hFFFF_FFF4;
          1:       redirect_pc = 32'h0000_0100;
          default: redirect_pc = $urandom & 32'h0000_FFFC;
        endcase
      end
      #1;
      if (!rst && imem_req_valid && imem_req_ready) begin
        lat   = directed ? 1 : int'($urandom_range(1, 3));
        m.due = c + lat;
        if (mq.size() > 0 && mq[$].due >= m.due) m.due = mq[$].due + 1;
        m.addr = imem_req_addr;
        mq.push_back(m);
      end
    end
    @(negedge clk);
    check("progress_instructions_delivered", 32'(pops > 200), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // ---------------- reference model + monitor ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;
  exp_t        exp_q[$];
  exp_t        cur;
  logic [31:0] stream_ptr = RST_PC;  // next address of the expected stream
  logic [31:0] req_ptr    = RST_PC;  // next address the stage must request
  bit          fresh      = 1'b1;    // next valid IF/ID entry is a new one
  bit          prev_rst   = 1'b0;
  bit          flush_prev = 1'b0;
  bit          outst      = 1'b0;
  int          pops       = 0;
  int          dir_idx    = 0;
  bit          tput_pat[8] = '{0, 0, 1, 0, 1, 0, 1, 0};
`ifdef INSTR_FETCH_PERF_CNT_EN
  int          fetch_m = 0;
  int          stall_m = 0;
`endif

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back('{stream_ptr, mem_word(stream_ptr), stream_ptr + STEP});
      stream_ptr += STEP;
    end
  endtask

  always @(negedge clk) begin
    if (prev_rst) begin
      check("reset_if_id_valid", 32'(if_id_valid), 32'd0);
      check("reset_if_id_instr", if_id_instr, 32'd0);
      check("reset_if_id_pc", if_id_pc, 32'd0);
      check("reset_if_id_pc_plus4", if_id_pc_plus4, 32'd0);
`ifdef INSTR_FETCH_PERF_CNT_EN
      check("reset_perf_fetch", perf_fetch_cnt, 32'd0);
      check("reset_perf_stall", perf_stall_cnt, 32'd0);
`endif
    end
    if (rst) begin
      check("req_valid_low_in_reset", 32'(imem_req_valid), 32'd0);
      exp_q.delete();
      stream_ptr = RST_PC;
      req_ptr    = RST_PC;
      fresh      = 1'b1;
      flush_prev = 1'b0;
      outst      = 1'b0;
`ifdef INSTR_FETCH_PERF_CNT_EN
      fetch_m = 0;
      stall_m = 0;
`endif
    end else begin
      if (imem_req_valid) begin
        check("req_addr", imem_req_addr, req_ptr);
        check("single_outstanding", 32'(outst), 32'd0);
      end
      if (flush_prev) check("flush_after_redirect", 32'(if_id_valid), 32'd0);
      if (if_id_valid) begin
        if (fresh) begin
          refill();
          cur = exp_q.pop_front();
          fresh = 1'b0;
          pops++;
`ifdef INSTR_FETCH_PERF_CNT_EN
          fetch_m++;
`endif
        end
        check("if_id_pc", if_id_pc, cur.pc);
        check("if_id_instr", if_id_instr, cur.instr);
        check("if_id_pc_plus4", if_id_pc_plus4, cur.pc4);
      end
      if (dir_idx < 8) begin
        check("throughput_pattern", 32'(if_id_valid), 32'(tput_pat[dir_idx]));
        dir_idx++;
      end
`ifdef INSTR_FETCH_PERF_CNT_EN
      check("perf_fetch_cnt", perf_fetch_cnt, 32'(fetch_m));
      check("perf_stall_cnt", perf_stall_cnt, 32'(stall_m));
      if (if_id_valid && id_stall) stall_m++;
`endif
      // Advance the model to what the coming edge will do.
      flush_prev = redirect_valid;
      if (redirect_valid) begin
        exp_q.delete();
        stream_ptr = redirect_pc;
        req_ptr    = redirect_pc;
        fresh      = 1'b1;
      end else begin
        if (if_id_valid && !id_stall) fresh = 1'b1;
        if (imem_req_valid && imem_req_ready) req_ptr += STEP;
      end
      if (imem_resp_valid) outst = 1'b0;
      if (imem_req_valid && imem_req_ready) outst = 1'b1;
    end
    prev_rst = rst;
  end

endmodule
